// File: rtl/uart_dbg_burst_master.sv
// UART-driven debug bus master: decodes a byte command stream into halt/resume,
// single and burst (incrementing or fixed-address) bus accesses, returning read data over UART.
module uart_dbg_burst_master #(
  parameter int ADDR_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_active,
  input  logic                    tx_done,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [7:0]              bus_wdata,
  input  logic [7:0]              bus_rdata,
  input  logic                    bus_ack,
  output logic                    cpu_halt,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AB_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_WDATA, S_BUS_WR, S_BUS_RD, S_TX_START, S_TX_WAIT
  } state_t;

  state_t           state;
  logic             cmd_write;
  logic             cmd_burst;
  logic             cmd_fixed;
  logic [AB_W-1:0]  addr_cnt;
  logic [CNT_W-1:0] remaining;
  logic [TW-1:0]    tmo_cnt;
  logic             tmo_run;
  logic             tmo_hit;

  // Fixed-address bursts keep hammering one port register; otherwise step and wrap.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic fixed);
    return fixed ? a : a + AW'(1);
  endfunction

  assign busy    = (state != S_IDLE);
  assign tmo_run = (state == S_ADDR) || (state == S_COUNT) || (state == S_WDATA);
  assign tmo_hit = tmo_run && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cmd_write   <= 1'b0;
      cmd_burst   <= 1'b0;
      cmd_fixed   <= 1'b0;
      addr_cnt    <= '0;
      remaining   <= '0;
      tmo_cnt     <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      cpu_halt    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      tx_start    <= 1'b0;
      if (!tmo_run || rx_valid) tmo_cnt <= '0;
      else                      tmo_cnt <= tmo_cnt + TW'(1);

      if (tmo_hit) begin
        err_timeout <= 1'b1;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_valid) begin
              if (rx_data == 8'h00) begin
                cpu_halt <= 1'b1;
              end else if (rx_data == 8'h01) begin
                cpu_halt <= 1'b0;
              end else if (rx_data <= 8'h07) begin
                // Opcode bits: [0]=read, [2]=burst, [1] with [2]=fixed address.
                cmd_write <= ~rx_data[0];
                cmd_burst <= rx_data[2];
                cmd_fixed <= rx_data[2] & rx_data[1];
                addr_cnt  <= '0;
                remaining <= '0;
                state     <= S_ADDR;
              end
            end
          end
          S_ADDR: begin
            if (rx_valid) begin
              bus_addr <= (bus_addr << 8) | AW'(rx_data);
              addr_cnt <= addr_cnt + AB_W'(1);
              if (addr_cnt == AB_W'(ADDR_BYTES - 1)) begin
                if (cmd_burst)      state <= S_COUNT;
                else if (cmd_write) state <= S_WDATA;
                else                state <= S_BUS_RD;
              end
            end
          end
          S_COUNT: begin
            if (rx_valid) begin
              remaining <= CNT_W'(rx_data);
              state     <= cmd_write ? S_WDATA : S_BUS_RD;
            end
          end
          S_WDATA: begin
            if (rx_valid) begin
              bus_wdata <= rx_data;
              state     <= S_BUS_WR;
            end
          end
          S_BUS_WR: begin
            if (!bus_req) begin
              bus_req <= 1'b1;
              bus_we  <= 1'b1;
            end else if (bus_ack) begin
              bus_req <= 1'b0;
              if (remaining == '0) begin
                state <= S_IDLE;
              end else begin
                remaining <= remaining - CNT_W'(1);
                bus_addr  <= next_addr(bus_addr, cmd_fixed);
                state     <= S_WDATA;
              end
            end
          end
          S_BUS_RD: begin
            if (!bus_req) begin
              bus_req <= 1'b1;
              bus_we  <= 1'b0;
            end else if (bus_ack) begin
              bus_req <= 1'b0;
              tx_data <= bus_rdata;
              state   <= S_TX_START;
            end
          end
          S_TX_START: begin
            if (!tx_active) begin
              tx_start <= 1'b1;
              state    <= S_TX_WAIT;
            end
          end
          S_TX_WAIT: begin
            // Only one byte in flight: the next read waits for the UART to finish.
            if (tx_done && !tx_start) begin
              if (remaining == '0) begin
                state <= S_IDLE;
              end else begin
                remaining <= remaining - CNT_W'(1);
                bus_addr  <= next_addr(bus_addr, cmd_fixed);
                state     <= S_BUS_RD;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
